// File: rtl/wb_port_scheduler.sv
// Writeback port scheduler: arbitrates the register-file write port among
// load return, JAL link and ALU, tracking outstanding load tags in order.
module wb_port_scheduler #(
  parameter int LOAD_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_rd,
  input  logic                          jal_valid,
  input  logic                          load_issue,
  input  logic [4:0]                    load_rd,
  input  logic                          dmem_ready,
  output logic [1:0]                    WRITETDATASELECT,
  output logic                          reg_write_en,
  output logic [4:0]                    reg_write_addr,
  output logic                          alu_stall,
  output logic                          jal_stall,
  output logic                          load_stall,
  output logic [$clog2(LOAD_DEPTH):0]   loads_pending,
  output logic                          proto_err
);

  localparam int AW = $clog2(LOAD_DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]            tag_q [LOAD_DEPTH];
  logic [LOAD_DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic push, pop, empty;
  logic jal_haz, alu_haz;
  logic ld_gnt, jal_gnt, alu_gnt;

  assign empty      = (cnt_q == '0);
  assign load_stall = (cnt_q == CW'(LOAD_DEPTH));
  assign push       = load_issue && !load_stall;
  assign pop        = dmem_ready && !empty;

  assign loads_pending = cnt_q;
  assign proto_err     = err_q;

  // Lookup sees pre-edge contents, so a same-cycle push never hazards.
  always_comb begin
    jal_haz = 1'b0;
    alu_haz = 1'b0;
    for (int i = 0; i < LOAD_DEPTH; i++) begin
      if (vld_q[i] && tag_q[i] == 5'd31)
        jal_haz = 1'b1;
      if (vld_q[i] && tag_q[i] == alu_rd && alu_rd != 5'd0)
        alu_haz = 1'b1;
    end
  end

  assign ld_gnt  = pop;
  assign jal_gnt = !ld_gnt && jal_valid && !jal_haz;
  assign alu_gnt = !ld_gnt && !jal_gnt && alu_valid && !alu_haz;

  assign alu_stall = alu_valid && !alu_gnt;
  assign jal_stall = jal_valid && !jal_gnt;

  always_comb begin
    WRITETDATASELECT = 2'b00;
    reg_write_addr   = 5'd0;
    unique case (1'b1)
      ld_gnt: begin
        WRITETDATASELECT = 2'b01;
        reg_write_addr   = tag_q[rd_ptr_q];
      end
      jal_gnt: begin
        WRITETDATASELECT = 2'b10;
        reg_write_addr   = 5'd31;
      end
      alu_gnt: begin
        WRITETDATASELECT = 2'b00;
        reg_write_addr   = alu_rd;
      end
      default: ;
    endcase
  end

  assign reg_write_en = (ld_gnt || jal_gnt || alu_gnt)
                      && (reg_write_addr != 5'd0);

  always_comb begin
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    err_d    = err_q || (dmem_ready && empty);
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + AW'(1);
    end
    if (push) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < LOAD_DEPTH; i++)
        tag_q[i] <= 5'd0;
    end else begin
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      if (push)
        tag_q[wr_ptr_q] <= load_rd;
    end
  end

endmodule
